// File: rtl/led_matrix_pkg.sv
// ---------------------------------------------------------------------------
// led_matrix_pkg
// Shared definitions for the LED matrix scanner:
//   - scan_state_e : scan FSM encoding (IDLE / BLANK / ON)
//   - pin_level()  : maps a logical "active" bit onto a pin level for a
//                    given polarity (act_hi = 1 -> active drives high)
//   - timing_ok()  : slot timing sanity check; the ON phase must be long
//                    enough to hold at least one full PWM period
// ---------------------------------------------------------------------------
package led_matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } scan_state_e;

  localparam bit PIN_ACT_HIGH = 1'b1;
  localparam bit PIN_ACT_LOW  = 1'b0;

  function automatic logic pin_level(input logic active, input bit act_hi);
    return act_hi ? active : ~active;
  endfunction

  // BLANK must be at least one clock so the blank phase has a terminal count.
  function automatic bit timing_ok(input int prescale, input int blank, input int bright_w);
    return (blank >= 1) && (prescale > blank + (1 << bright_w));
  endfunction

endpackage

// File: rtl/led_matrix_scan_drv_if.sv
// ---------------------------------------------------------------------------
// led_matrix_scan_drv_if
// Bundles the frame handshake, brightness/enable controls and matrix pins of
// the LED matrix scanner.
//   master : frame producer / board top side (drives enable, frame, bright)
//   slave  : the scanner itself (drives ready, rows, cols, frame sync)
// Signals:
//   i_Enable      scan enable
//   i_Frame_Data  ROWS*COLS bitmap, bit r*COLS+c = row r column c, 1 = lit
//   i_Frame_DV    frame valid (accepted when i_Frame_DV && o_Frame_Ready)
//   o_Frame_Ready shadow buffer free
//   i_Bright      PWM brightness code, 0 = dark
//   o_Rows        row drive pins
//   o_Cols        column drive pins
//   o_Frame_Sync  one-cycle pulse on entry to the row-0 blank phase
// ---------------------------------------------------------------------------
interface led_matrix_scan_drv_if #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int BRIGHT_W = 4
);
  logic                 i_Enable;
  logic [ROWS*COLS-1:0] i_Frame_Data;
  logic                 i_Frame_DV;
  logic                 o_Frame_Ready;
  logic [BRIGHT_W-1:0]  i_Bright;
  logic [ROWS-1:0]      o_Rows;
  logic [COLS-1:0]      o_Cols;
  logic                 o_Frame_Sync;

  modport master (
    output i_Enable, i_Frame_Data, i_Frame_DV, i_Bright,
    input  o_Frame_Ready, o_Rows, o_Cols, o_Frame_Sync
  );

  modport slave (
    input  i_Enable, i_Frame_Data, i_Frame_DV, i_Bright,
    output o_Frame_Ready, o_Rows, o_Cols, o_Frame_Sync
  );
endinterface

// File: rtl/led_row_timer.sv
// ---------------------------------------------------------------------------
// led_row_timer
// Slot timing for the matrix scanner. Each row slot is PRESCALE clocks: BLANK
// clocks with everything off, then PRESCALE-BLANK clocks with the row driven.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   enable_i        scan enable; low forces IDLE and row 0 on the next edge
//   phase_o         current scan state (IDLE / BLANK / ON)
//   row_o           row index of the running slot
//   pwm_cnt_o       PWM counter, cleared on ON entry, free-running wrap
//   slot_end_o      last clock of the ON phase of the running slot
//   frame_wrap_o    running slot is the last row; with slot_end_o this marks
//                   the frame boundary
// ---------------------------------------------------------------------------
module led_row_timer
  import led_matrix_pkg::*;
#(
  parameter  int ROWS     = 8,
  parameter  int PRESCALE = 65536,
  parameter  int BLANK    = 16,
  parameter  int BRIGHT_W = 4,
  localparam int CW       = $clog2(PRESCALE),
  localparam int RW       = $clog2(ROWS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  output scan_state_e         phase_o,
  output logic [RW-1:0]       row_o,
  output logic [BRIGHT_W-1:0] pwm_cnt_o,
  output logic                slot_end_o,
  output logic                frame_wrap_o
);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  scan_state_e         state_q;
  logic [CW-1:0]       slot_cnt_q;   // position inside the slot, 0..PRESCALE-1
  logic [RW-1:0]       row_q;
  logic [BRIGHT_W-1:0] pwm_cnt_q;

  assign phase_o      = state_q;
  assign row_o        = row_q;
  assign pwm_cnt_o    = pwm_cnt_q;
  assign slot_end_o   = (state_q == ST_ON) && (slot_cnt_q == SLOT_LAST);
  assign frame_wrap_o = (row_q == ROW_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      slot_cnt_q <= '0;
      row_q      <= '0;
      pwm_cnt_q  <= '0;
    end else if (!enable_i) begin
      state_q    <= ST_IDLE;
      slot_cnt_q <= '0;
      row_q      <= '0;
      pwm_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q    <= ST_BLANK;
          slot_cnt_q <= '0;
          row_q      <= '0;
        end
        ST_BLANK: begin
          // The slot counter keeps running into ON so slot_end lands on PRESCALE-1.
          slot_cnt_q <= slot_cnt_q + 1'b1;
          if (slot_cnt_q == BLANK_LAST) begin
            state_q   <= ST_ON;
            pwm_cnt_q <= '0;
          end
        end
        ST_ON: begin
          pwm_cnt_q <= pwm_cnt_q + 1'b1;
          if (slot_end_o) begin
            state_q    <= ST_BLANK;
            slot_cnt_q <= '0;
            row_q      <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
          end else begin
            slot_cnt_q <= slot_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          slot_cnt_q <= '0;
          row_q      <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/led_matrix_scan_drv.sv
// ---------------------------------------------------------------------------
// led_matrix_scan_drv
// Double-buffered ROWS x COLS LED matrix scanner with per-row blanking,
// per-frame PWM brightness and configurable pin polarity.
// Ports:
//   i_CLK     clock, all logic on posedge
//   i_RST_N   asynchronous active-low reset; aborts the scan at once
//   scan_if   led_matrix_scan_drv_if.slave: enable, frame handshake,
//             brightness, row/column pins and frame sync
// A frame is written into the shadow buffer on accept and copied into the
// displayed (active) buffer only at a frame boundary or when the scan
// starts from IDLE, so a frame is never shown partially.
// ---------------------------------------------------------------------------
module led_matrix_scan_drv
  import led_matrix_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int PRESCALE   = 65536,
  parameter int BLANK      = 16,
  parameter int BRIGHT_W   = 4,
  parameter bit ROW_ACT_HI = PIN_ACT_HIGH,
  parameter bit COL_ACT_HI = PIN_ACT_LOW
) (
  input logic                  i_CLK,
  input logic                  i_RST_N,
  led_matrix_scan_drv_if.slave scan_if
);

  localparam int RW     = $clog2(ROWS);
  localparam bit CFG_OK = timing_ok(PRESCALE, BLANK, BRIGHT_W);

  if (!CFG_OK) begin : g_cfg_error
    $error("led_matrix_scan_drv: need BLANK >= 1 and PRESCALE > BLANK + 2**BRIGHT_W");
  end

  scan_state_e         phase;
  logic [RW-1:0]       row_idx;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic                slot_end;
  logic                frame_wrap;

  led_row_timer #(
    .ROWS     (ROWS),
    .PRESCALE (PRESCALE),
    .BLANK    (BLANK),
    .BRIGHT_W (BRIGHT_W)
  ) u_row_timer (
    .clk_i        (i_CLK),
    .rst_ni       (i_RST_N),
    .enable_i     (scan_if.i_Enable),
    .phase_o      (phase),
    .row_o        (row_idx),
    .pwm_cnt_o    (pwm_cnt),
    .slot_end_o   (slot_end),
    .frame_wrap_o (frame_wrap)
  );

  logic [ROWS*COLS-1:0] active_q;
  logic [ROWS*COLS-1:0] shadow_q;
  logic                 pending_q;
  logic [BRIGHT_W-1:0]  bright_q;
  logic                 sync_q;

  logic accept;
  logic frame_start;

  assign accept = scan_if.i_Frame_DV && !pending_q;
  // Row-0 blank is entered either from IDLE or at the wrap of the last row.
  assign frame_start = scan_if.i_Enable &&
                       ((phase == ST_IDLE) || (slot_end && frame_wrap));

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      bright_q  <= '0;
      sync_q    <= 1'b0;
    end else begin
      sync_q <= frame_start;
      if (frame_start) begin
        bright_q <= scan_if.i_Bright;
      end
      // Accept is blocked while pending, so swap and accept never collide;
      // a frame accepted on the boundary itself waits for the next boundary.
      if (frame_start && pending_q) begin
        active_q  <= shadow_q;
        pending_q <= 1'b0;
      end else if (accept) begin
        shadow_q  <= scan_if.i_Frame_Data;
        pending_q <= 1'b1;
      end
    end
  end

  logic [COLS-1:0] row_bits;
  logic            cols_enable;
  logic [ROWS-1:0] rows_pin;
  logic [COLS-1:0] cols_pin;

  assign row_bits    = active_q[row_idx*COLS +: COLS];
  assign cols_enable = (phase == ST_ON) && (pwm_cnt < bright_q);

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_rows
    assign rows_pin[gi] = pin_level((phase == ST_ON) && (row_idx == RW'(gi)), ROW_ACT_HI);
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_cols
    assign cols_pin[gi] = pin_level(row_bits[gi] && cols_enable, COL_ACT_HI);
  end

  assign scan_if.o_Rows        = rows_pin;
  assign scan_if.o_Cols        = cols_pin;
  assign scan_if.o_Frame_Ready = ~pending_q;
  assign scan_if.o_Frame_Sync  = sync_q;

endmodule
